// File: rtl/coeff_loader.sv
// Loads the FIR coefficient array from a valid/ready byte stream, writing entries in index order.
// Optional trailing checksum beat and CHECK state under `COEFF_LOADER_CHECKSUM_EN.
module coeff_loader #(
  parameter int NUM_TAPS = 71,
  parameter int ADDR_W   = 7,
  parameter int COEFF_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COEFF_W-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic [COEFF_W-1:0] coefficient,
  output logic               write_en,
  output logic               busy,
  output logic               done,
  output logic               error
);

`ifdef COEFF_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_idx, r_addr;
  logic [COEFF_W-1:0]   r_coeff;
  logic                 r_we;
  logic                 w_active, w_acc, w_go, w_last;

`ifdef COEFF_LOADER_CHECKSUM_EN
  assign w_active = (r_state == LOAD) || (r_state == CHECK);
`else
  assign w_active = (r_state == LOAD);
`endif

  assign w_acc  = s_valid && w_active;
  assign w_go   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_idx == LAST_IDX);

  assign s_ready     = w_active;
  assign busy        = w_active;
  assign done        = (r_state == DONE);
  assign addr        = r_addr;
  assign coefficient = r_coeff;
  assign write_en    = r_we;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = LOAD;
`ifdef COEFF_LOADER_CHECKSUM_EN
      LOAD:       if (w_acc && w_last) w_next = CHECK;
      CHECK:      if (w_acc) w_next = DONE;
`else
      LOAD:       if (w_acc && w_last) w_next = DONE;
`endif
      default:    w_next = IDLE;
    endcase
  end

  // Write port: one registered strobe per coefficient beat; addr/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_addr  <= '0;
      r_coeff <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_go) begin
        r_idx <= '0;
      end else if (r_state == LOAD && w_acc) begin
        r_addr  <= r_idx;
        r_coeff <= s_data;
        r_we    <= 1'b1;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [COEFF_W-1:0] r_sum;
  logic               r_error;

  // Running modulo sum of the raw coefficient bytes; compared against the beat taken in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else if (w_go) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else if (r_state == LOAD && w_acc) begin
      r_sum <= r_sum + s_data;
    end else if (r_state == CHECK && w_acc) begin
      r_error <= (r_sum != s_data);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: cycle table for handshake basics, then full load sessions.
// Build with or without COEFF_LOADER_CHECKSUM_EN; the checksum sessions follow the macro.
module tb_coeff_loader;
  logic       clk, rst, start, s_valid;
  logic [7:0] s_data;
  logic       s_ready, write_en, busy, done, error;
  logic [6:0] addr;
  logic [7:0] coefficient;

  int total = 0;
  int bad   = 0;
  logic [6:0] wa[$];
  logic [7:0] wc[$];

  coeff_loader #(.NUM_TAPS(71), .ADDR_W(7), .COEFF_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .addr(addr), .coefficient(coefficient), .write_en(write_en),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, vld;
    logic [7:0] d;
    logic       rdy, we;
    logic [6:0] a;
    logic [7:0] c;
    logic       bsy, dn;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge, writes logged.
  task automatic cyc();
    @(posedge clk); #1;
    if (write_en) begin
      wa.push_back(addr);
      wc.push_back(coefficient);
    end
  endtask

  function automatic logic [7:0] val(input int pat, input int k);
    logic [7:0] v;
    v = (pat == 1) ? 8'hFF : 8'(k);
    return v;
  endfunction

  task automatic load(input int gap, input int pat, input int n, input int start_at);
    wa.delete(); wc.delete();
    start = 1'b1; s_valid = 1'b0; cyc(); start = 1'b0;
    chk("start_ready", s_ready, 1);
    chk("start_busy", busy, 1);
    for (int k = 0; k < n; k++) begin
      start = (k == start_at);
      s_valid = 1'b1; s_data = val(pat, k); cyc();
      start = 1'b0;
      if (gap != 0) begin
        s_valid = 1'b0; s_data = 8'hAA; cyc();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic finish(input logic [7:0] ck, input logic exp_err);
`ifdef COEFF_LOADER_CHECKSUM_EN
    chk("pre_ck_busy", busy, 1);
    chk("pre_ck_done", done, 0);
    s_valid = 1'b1; s_data = ck; cyc(); s_valid = 1'b0;
    chk("ck_no_write", write_en, 0);
    chk("ck_addr_hold", addr, 70);
`else
    if (ck == 8'h00) chk("no_ck_err", exp_err, 0);
`endif
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_error", error, exp_err);
  endtask

  task automatic check_writes(input int n, input int pat);
    int first_bad;
    first_bad = -1;
    chk("wr_count", wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      if (first_bad < 0 && (wa[i] !== 7'(i) || wc[i] !== val(pat, i))) first_bad = i;
    end
    chk("wr_order", first_bad, -1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;

    //           rst  st  vld  d      rdy we  a  c      bsy dn
    tv[0] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,7'd0,8'h00,1'b0,1'b0};
    tv[1] = '{1'b0,1'b0,1'b1,8'h05, 1'b0,1'b0,7'd0,8'h00,1'b0,1'b0};
    tv[2] = '{1'b0,1'b1,1'b1,8'h05, 1'b1,1'b0,7'd0,8'h00,1'b1,1'b0};
    tv[3] = '{1'b0,1'b0,1'b1,8'h10, 1'b1,1'b1,7'd0,8'h10,1'b1,1'b0};
    tv[4] = '{1'b0,1'b0,1'b0,8'h63, 1'b1,1'b0,7'd0,8'h10,1'b1,1'b0};
    tv[5] = '{1'b0,1'b0,1'b1,8'hF0, 1'b1,1'b1,7'd1,8'hF0,1'b1,1'b0};
    tv[6] = '{1'b0,1'b1,1'b1,8'h22, 1'b1,1'b1,7'd2,8'h22,1'b1,1'b0};
    tv[7] = '{1'b0,1'b0,1'b0,8'h22, 1'b1,1'b0,7'd2,8'h22,1'b1,1'b0};
    tv[8] = '{1'b1,1'b0,1'b1,8'h33, 1'b0,1'b0,7'd0,8'h00,1'b0,1'b0};
    tv[9] = '{1'b0,1'b0,1'b1,8'h44, 1'b0,1'b0,7'd0,8'h00,1'b0,1'b0};

    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      rst = tv[i].rst; start = tv[i].start; s_valid = tv[i].vld; s_data = tv[i].d;
      cyc();
      chk($sformatf("v%0d_ready", i), s_ready, tv[i].rdy);
      chk($sformatf("v%0d_we", i), write_en, tv[i].we);
      chk($sformatf("v%0d_addr", i), addr, tv[i].a);
      chk($sformatf("v%0d_coef", i), coefficient, tv[i].c);
      chk($sformatf("v%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("v%0d_done", i), done, tv[i].dn);
      chk($sformatf("v%0d_error", i), error, 0);
    end
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    cyc();

    // Back-to-back 0..70; sum of 0..70 = 2485 = 0xB5 mod 256.
    load(0, 0, 71, -1);
`ifndef COEFF_LOADER_CHECKSUM_EN
    chk("b2b_last_we", write_en, 1);
    chk("b2b_last_addr", addr, 70);
`endif
    finish(8'hB5, 1'b0);
    n0 = wa.size();
    s_valid = 1'b1; s_data = 8'h77;
    cyc(); cyc(); cyc();
    chk("post_done_ready", s_ready, 0);
    chk("post_done_nowr", wa.size(), n0);
    chk("post_done_hold", done, 1);
    s_valid = 1'b0;
    check_writes(71, 0);

    // Alternating s_valid.
    load(1, 0, 71, -1);
    finish(8'hB5, 1'b0);
    check_writes(71, 0);

    // start pulsed alongside beat 10 is ignored.
    load(0, 0, 71, 10);
    finish(8'hB5, 1'b0);
    check_writes(71, 0);

    // Reset after 30 beats aborts the session.
    load(0, 0, 30, -1);
    rst = 1'b1; cyc();
    chk("abort_ready", s_ready, 0);
    chk("abort_we", write_en, 0);
    chk("abort_addr", addr, 0);
    chk("abort_coef", coefficient, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0; s_valid = 1'b1; s_data = 8'h55;
    cyc(); cyc();
    chk("abort_idle_nowr", wa.size(), 30);
    chk("abort_idle_busy", busy, 0);
    s_valid = 1'b0;
    check_writes(30, 0);
    load(0, 0, 71, -1);
    finish(8'hB5, 1'b0);
    check_writes(71, 0);

    // All 0xFF: correct checksum is 71*255 mod 256 = 0xB9.
    load(0, 1, 71, -1);
    finish(8'hB9, 1'b0);
    check_writes(71, 1);
`ifdef COEFF_LOADER_CHECKSUM_EN
    load(0, 1, 71, -1);
    finish(8'h00, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_done_clr", done, 0);
    chk("restart_err_clr", error, 0);
    chk("restart_busy", busy, 1);
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
